// File: rtl/imem_pkg.sv
// imem_pkg: shared mode/fault encodings, NOP word and index-width helper for the instruction memory.
package imem_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROG  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        F_NONE     = 2'b00,
        F_MISALIGN = 2'b01,
        F_RANGE    = 2'b10
    } fault_t;

    // Wide enough for any sensible INSTR_W; callers truncate with a size cast.
    localparam logic [255:0] NOP = '0;

    function automatic int idx_w(input int depth);
        return depth > 1 ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/imem_fetch_unit_if.sv
// imem_fetch_unit_if: fetch request/response handshake between the fetch stage and the instruction memory.
interface imem_fetch_unit_if #(
    parameter int ADDR_W  = 18,
    parameter int INSTR_W = 18
) ();
    import imem_pkg::*;

    logic               req_valid;
    logic               req_ready;
    logic [ADDR_W-1:0]  req_addr;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [INSTR_W-1:0] rsp_instr;
    fault_t             rsp_fault;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_instr, rsp_fault
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_instr, rsp_fault
    );
endinterface

// File: rtl/imem_array.sv
// imem_array: single-port DEPTH x INSTR_W RAM, synchronous write and registered read (block-RAM target).
module imem_array #(
    parameter int DEPTH   = 128,
    parameter int INSTR_W = 18,
    parameter int AW      = 7
) (
    input  logic               clk,
    input  logic               we,
    input  logic               re,
    input  logic [AW-1:0]      addr,
    input  logic [INSTR_W-1:0] wdata,
    output logic [INSTR_W-1:0] rdata
);
    logic [INSTR_W-1:0] mem [DEPTH];

    // No reset: contents and the read register survive rst_n by design.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit: programmable instruction memory behind a valid/ready fetch port with a one-entry response register.
// Define IMEM_FAULT_EN to enable misalignment/range checks on fetch addresses; otherwise addresses wrap modulo DEPTH.
module imem_fetch_unit
    import imem_pkg::*;
#(
    parameter int INSTR_W    = 18,
    parameter int ADDR_W     = 18,
    parameter int DEPTH      = 128,
    parameter int ALIGN_BITS = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     prog_en,
    input  logic                     prog_we,
    input  logic [idx_w(DEPTH)-1:0]  prog_idx,
    input  logic [INSTR_W-1:0]       prog_data,
    output logic                     prog_err,
    output mode_t                    mode,
    imem_fetch_unit_if.slave         bus
);
    localparam int IW = idx_w(DEPTH);

    mode_t              state, state_n;
    fault_t             fault_q, fault_c;
    logic               rsp_valid_q, use_nop, accept, ram_we, prog_bad;
    logic [ADDR_W-1:0]  word;
    logic [IW-1:0]      fetch_idx, ram_addr;
    logic [INSTR_W-1:0] rd_data;

    assign word = bus.req_addr >> ALIGN_BITS;

`ifdef IMEM_FAULT_EN
    localparam logic [ADDR_W-1:0] AMASK = ADDR_W'((1 << ALIGN_BITS) - 1);
    assign fetch_idx = IW'(word);
    assign fault_c   = (bus.req_addr & AMASK) != '0 ? F_MISALIGN :
                       word >= ADDR_W'(DEPTH)        ? F_RANGE    : F_NONE;
`else
    assign fetch_idx = IW'(word % ADDR_W'(DEPTH));
    assign fault_c   = F_NONE;
`endif

    // The single RAM port belongs to the programmer in PROG and to fetch otherwise.
    assign prog_bad = {1'b0, prog_idx} >= (IW+1)'(DEPTH);
    assign ram_we   = state == PROG && prog_we && !prog_bad;
    assign ram_addr = state == PROG ? prog_idx : fetch_idx;
    assign accept   = bus.req_valid && bus.req_ready;

    imem_array #(
        .DEPTH   (DEPTH),
        .INSTR_W (INSTR_W),
        .AW      (IW)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .re    (accept),
        .addr  (ram_addr),
        .wdata (prog_data),
        .rdata (rd_data)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = prog_en ? PROG : start ? RUN : IDLE;
            PROG:    state_n = prog_en ? PROG : RUN;
            RUN:     state_n = prog_en ? DRAIN : RUN;
            DRAIN:   state_n = (!rsp_valid_q || bus.rsp_ready) ? PROG : DRAIN;
            default: state_n = IDLE;
        endcase
        bus.req_ready = state == RUN && (!rsp_valid_q || bus.rsp_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            prog_err    <= 1'b0;
            rsp_valid_q <= 1'b0;
            fault_q     <= F_NONE;
            use_nop     <= 1'b1;
        end else begin
            state       <= state_n;
            rsp_valid_q <= accept || (rsp_valid_q && !bus.rsp_ready);
            if (state == PROG && prog_we && prog_bad) prog_err <= 1'b1;
            if (accept) begin
                fault_q <= fault_c;
                use_nop <= fault_c != F_NONE;
            end
        end
    end

    // use_nop masks the un-reset RAM read register after reset and for faulted fetches.
    assign mode          = state;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_fault = fault_q;
    assign bus.rsp_instr = use_nop ? INSTR_W'(NOP) : rd_data;
endmodule

// File: tb/tb_imem_fetch_unit.sv
// tb_imem_fetch_unit: randomized fetch traffic checked against an array/arithmetic reference of the memory.
module tb_imem_fetch_unit;
    localparam int DEPTH = 100;
    localparam int IW    = 7;
    localparam int AW    = 18;
    localparam int DW    = 18;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          prog_en = 1'b0;
    logic          prog_we = 1'b0;
    logic [IW-1:0] prog_idx = '0;
    logic [DW-1:0] prog_data = '0;
    logic          prog_err;
    logic [1:0]    mode;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] boot [4];
    int            exp_mode = 0;
    bit            exp_valid = 1'b0;
    bit            exp_perr = 1'b0;
    logic [DW-1:0] exp_instr = '0;
    logic [1:0]    exp_fault = '0;

    imem_fetch_unit_if #(.ADDR_W(AW), .INSTR_W(DW)) bus ();

    imem_fetch_unit #(
        .INSTR_W    (DW),
        .ADDR_W     (AW),
        .DEPTH      (DEPTH),
        .ALIGN_BITS (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .prog_en   (prog_en),
        .prog_we   (prog_we),
        .prog_idx  (prog_idx),
        .prog_data (prog_data),
        .prog_err  (prog_err),
        .mode      (mode),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected response for a fetch address, straight from the addressing rules.
    function automatic void resp(input logic [AW-1:0] a, output logic [DW-1:0] ins, output logic [1:0] f);
        int w;
        w = int'(a) / 4;
`ifdef IMEM_FAULT_EN
        if (int'(a) % 4 != 0) begin
            f = 2'b01; ins = '0;
        end else if (w >= DEPTH) begin
            f = 2'b10; ins = '0;
        end else begin
            f = 2'b00; ins = mem[w];
        end
`else
        f = 2'b00;
        ins = mem[w % DEPTH];
`endif
    endfunction

    task automatic drive(input bit v, input logic [AW-1:0] a, input bit rr);
        bus.req_valid = v;
        bus.req_addr  = a;
        bus.rsp_ready = rr;
    endtask

    // One clock: check ready before the edge, advance the model, check outputs after it.
    task automatic step();
        bit            acc;
        logic [DW-1:0] ni;
        logic [1:0]    nf;
        int            nm;
        #1;
        acc = exp_mode == 2 && (!exp_valid || bus.rsp_ready);
        check("req_ready", 32'(bus.req_ready), 32'(acc));
        acc = acc && bus.req_valid;
        resp(bus.req_addr, ni, nf);
        case (exp_mode)
            0:       nm = prog_en ? 1 : start ? 2 : 0;
            1:       nm = prog_en ? 1 : 2;
            2:       nm = prog_en ? 3 : 2;
            default: nm = (!exp_valid || bus.rsp_ready) ? 1 : 3;
        endcase
        if (exp_mode == 1 && prog_we) begin
            if (int'(prog_idx) < DEPTH) mem[prog_idx] = prog_data;
            else exp_perr = 1'b1;
        end
        if (acc) begin
            exp_valid = 1'b1;
            exp_instr = ni;
            exp_fault = nf;
        end else if (bus.rsp_ready) begin
            exp_valid = 1'b0;
        end
        exp_mode = nm;
        @(posedge clk);
        #1;
        check("mode", 32'(mode), 32'(exp_mode));
        check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_valid));
        check("prog_err", 32'(prog_err), 32'(exp_perr));
        if (exp_valid) begin
            check("rsp_instr", 32'(bus.rsp_instr), 32'(exp_instr));
            check("rsp_fault", 32'(bus.rsp_fault), 32'(exp_fault));
        end
    endtask

    task automatic reset_checks();
        check("rst_mode", 32'(mode), 32'(0));
        check("rst_req_ready", 32'(bus.req_ready), 32'(0));
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
        check("rst_rsp_instr", 32'(bus.rsp_instr), 32'(0));
        check("rst_rsp_fault", 32'(bus.rsp_fault), 32'(0));
        check("rst_prog_err", 32'(prog_err), 32'(0));
    endtask

    initial begin
        logic [AW-1:0] a;
        int            r;
        boot[0] = 18'h0F1E0;
        boot[1] = 18'h0F1E0;
        boot[2] = 18'h08010;
        boot[3] = 18'h03EE0;
        drive(1'b0, '0, 1'b0);
        #2;
        reset_checks();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        prog_en = 1'b1;
        step();
        for (int i = 0; i < DEPTH; i++) begin
            prog_we   = 1'b1;
            prog_idx  = IW'(i);
            prog_data = i < 4 ? boot[i] : DW'($urandom);
            step();
        end
        prog_we = 1'b0;
        prog_en = 1'b0;
        step();

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, AW'(4 * i), 1'b1);
            step();
            check("boot_word", 32'(bus.rsp_instr), 32'(boot[i]));
        end

        drive(1'b1, AW'(2), 1'b1);
        step();
        drive(1'b1, AW'(4 * DEPTH), 1'b1);
        step();
`ifndef IMEM_FAULT_EN
        check("wrap_word0", 32'(bus.rsp_instr), 32'(boot[0]));
`endif
        drive(1'b0, '0, 1'b1);
        step();

        drive(1'b1, AW'(8), 1'b1);
        step();
        drive(1'b1, AW'(12), 1'b0);
        repeat (3) step();
        drive(1'b1, AW'(12), 1'b1);
        step();

        drive(1'b1, AW'(4), 1'b1);
        step();
        drive(1'b0, '0, 1'b0);
        prog_en = 1'b1;
        step();
        step();
        bus.rsp_ready = 1'b1;
        step();
        prog_we   = 1'b1;
        prog_idx  = IW'(DEPTH);
        prog_data = DW'($urandom);
        step();
        prog_we = 1'b0;
        prog_en = 1'b0;
        step();

        repeat (400) begin
            r = int'($urandom_range(0, 9));
            if (r < 7) a = AW'(4 * $urandom_range(0, DEPTH - 1));
            else if (r < 8) a = AW'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
            else a = AW'($urandom_range(4 * DEPTH, (1 << AW) - 1));
            drive($urandom_range(0, 3) != 0, a, $urandom_range(0, 3) != 0);
            step();
        end

        drive(1'b1, AW'(8), 1'b1);
        step();
        rst_n = 1'b0;
        #1;
        exp_mode  = 0;
        exp_valid = 1'b0;
        exp_perr  = 1'b0;
        reset_checks();
        drive(1'b0, '0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        drive(1'b1, AW'(0), 1'b1);
        step();
        check("kept_word0", 32'(bus.rsp_instr), 32'(boot[0]));
        drive(1'b1, AW'(12), 1'b1);
        step();
        check("kept_word3", 32'(bus.rsp_instr), 32'(boot[3]));
        drive(1'b0, '0, 1'b1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_fetch_unit.md
# imem_fetch_unit

Parametrised instruction memory with a synchronous read port behind a valid/ready fetch handshake, plus a boot-time programming port. It replaces the fixed, combinational 18-bit, 101-entry ROM that feeds the fetch stage. It adds:
- depth, width and alignment generics;
- a mode FSM for loading code;
- a one-entry output register for back-pressure;
- fault reporting for bad fetch addresses.

## Interface
Parameters:
- INSTR_W, 18, instruction width in bits
- ADDR_W, 18, fetch byte-address width
- DEPTH, 128, number of instruction words (power of two not required)
- ALIGN_BITS, 2, byte-offset bits dropped for word alignment

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  IDLE -> RUN request
- prog_en  in  1  request/hold programming mode
- prog_we  in  1  write strobe, honoured only in PROG
- prog_idx  in  $clog2(DEPTH)  word index to write
- prog_data  in  INSTR_W  instruction word to write
- prog_err  out  1  sticky: a write targeted idx >= DEPTH
- mode  out  2  current FSM state (encoding from package)
- req_valid  in  1  fetch request present
- req_ready  out  1  fetch request accepted this cycle when high with req_valid
- req_addr  in  ADDR_W  fetch byte address
- rsp_valid  out  1  response register holds data
- rsp_ready  in  1  consumer takes response
- rsp_instr  out  INSTR_W  fetched instruction
- rsp_fault  out  2  00 none, 01 misaligned, 10 out-of-range

## Operation
- FSM states: IDLE, PROG, RUN, DRAIN.
  - IDLE: prog_en -> PROG; else start -> RUN. prog_en wins when both are high.
  - PROG: prog_en low -> RUN.
  - RUN: prog_en high -> DRAIN.
  - DRAIN: once !rsp_valid (or rsp_valid && rsp_ready) -> PROG.
- Programming: in PROG, prog_we writes prog_data to word prog_idx at the clock edge.
  - prog_idx >= DEPTH: write dropped, prog_err set. prog_err clears only on reset.
- Fetch: idx = req_addr >> ALIGN_BITS. req_ready = (mode==RUN) && (!rsp_valid || rsp_ready).
- An accepted request loads the response register on the next edge.
- Fault priority (IMEM_FAULT_EN defined): misaligned > out-of-range. A faulted response carries rsp_instr = NOP (all zeros).
- rsp_valid clears on rsp_ready unless a new request is accepted the same cycle. In that case it stays high with the new data (back-to-back, no bubble).
- Response register holds its value while rsp_valid && !rsp_ready.
- Memory contents are not reset and are preserved across rst_n. Reading a never-written word returns an undefined value.

## Timing
- Reset values: mode=IDLE, req_ready=0, rsp_valid=0, rsp_instr=0, rsp_fault=00, prog_err=0.
- Fetch latency: 1 cycle (request edge N -> rsp_valid at N+1). Throughput: 1 per cycle while rsp_ready stays high.
- Write-then-read: a word written in PROG is readable by the first RUN fetch, with no extra delay.
- Mode change: one edge per transition; req_ready is low in IDLE, PROG and DRAIN.
- Reset mid-fetch: an outstanding response is discarded and rsp_valid is low asynchronously.
- Reset mid-program: the write in that cycle may be lost; other words keep their contents.

## Configuration
- IMEM_FAULT_EN defined: alignment and range checks active, rsp_fault driven as above.
- IMEM_FAULT_EN undefined:
  - low ALIGN_BITS of req_addr are ignored;
  - idx wraps modulo DEPTH;
  - rsp_fault is tied to 00;
  - no fault logic is synthesised.
- prog_err is present in both builds.

## Structure
- Package imem_pkg holds:
  - the mode enum (IDLE=0, PROG=1, RUN=2, DRAIN=3);
  - the fault-code enum;
  - the NOP constant;
  - a function computing index width from DEPTH.
- Sub-module imem_array: single-port RAM with synchronous write and registered read, DEPTH x INSTR_W. It is the inference target for block RAM.

## Test plan
- Reset, then prog_en=1; write idx0..3 = 0x0F1E0, 0x0F1E0, 0x08010, 0x03EE0; drop prog_en -> mode goes PROG->RUN. Fetch addr 0,4,8,12 with rsp_ready=1 -> four consecutive responses with those values, 1-cycle latency, no bubbles.
- Fetch addr 0x2 (IMEM_FAULT_EN) -> rsp_fault=01, rsp_instr=0. Fetch addr 4*DEPTH -> rsp_fault=10. Without the macro, addr 4*DEPTH returns word 0.
- Hold rsp_ready=0 for 3 cycles after a fetch -> rsp_instr stable, req_ready=0. Release -> the next request is accepted the same cycle.
- In RUN with a pending response, raise prog_en -> mode=DRAIN until rsp_ready, then PROG. In PROG, write idx=DEPTH -> prog_err=1 and no word changes.
- Assert rst_n=0 with rsp_valid=1 -> rsp_valid drops before the next edge, mode=IDLE. Previously written words are still readable after restart.
